// File: rtl/serial_pattern_generator.sv
// -----------------------------------------------------------------------------
// serial_pattern_generator
//
// Serialises a programmed bit pattern onto a 1-bit line, MSB (bit len-1) first,
// one bit per clock. One command can repeat the pattern several times, either
// back-to-back or separated by a programmable number of idle cycles. This
// produces both overlapping and non-overlapping stimulus for the sequence
// detectors.
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous active-low reset
//   start      in   command strobe, only sampled in IDLE
//   abort      in   ends the current command in SEND/GAP (no done pulse)
//   pattern    in   [WIDTH-1:0] bits to send
//   len        in   [LW-1:0] bits per repetition (clamped to WIDTH, 0 = none)
//   repeats    in   [7:0] repetition count (0 behaves as 1)
//   gap        in   [3:0] idle cycles between repetitions
//   out        out  serial data, 0 whenever out_valid is 0
//   out_valid  out  out carries a pattern bit this cycle
//   busy       out  high in SEND and GAP
//   done       out  single-cycle completion pulse
//
// Handshake: start is a level sampled at the clock edge while IDLE; there is
// no ready. A start seen in any other state is dropped, not queued. abort has
// priority over start in IDLE.
// -----------------------------------------------------------------------------
module serial_pattern_generator #(
  parameter  int WIDTH = 8,
  localparam int LW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic [7:0]       repeats,
  input  logic [3:0]       gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d, len_eff;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       rep_q, rep_d;
  logic [3:0]       gap_q, gap_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             out_q, out_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign len_eff = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          pat_d = pattern;
          len_d = len_eff;
          // rep counts repetitions still to send, including the current one
          rep_d = (repeats == 8'd0) ? 8'd1 : repeats;
          gap_d = gap;
          if (len_eff == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SEND;
            idx_d   = IW'(len_eff - LW'(1));
          end
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q == '0) begin
          if (rep_q > 8'd1) begin
            rep_d = rep_q - 8'd1;
            if (gap_q != 4'd0) begin
              state_d = S_GAP;
              gcnt_d  = gap_q;
            end else begin
              idx_d = IW'(len_q - LW'(1));
            end
          end else begin
            state_d = S_DONE;
          end
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gcnt_q == 4'd1) begin
          state_d = S_SEND;
          idx_d   = IW'(len_q - LW'(1));
        end else begin
          gcnt_d = gcnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so that the first bit shows up
  // in the cycle right after the edge that accepted start.
  always_comb begin
    ov_d   = (state_d == S_SEND);
    out_d  = ov_d & pat_d[idx_d];
    busy_d = (state_d == S_SEND) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      out_q   <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = ov_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
